mem_loader: RTL and testbench

//  Button-driven program writer: the entry-side counterpart of the pc/mem/sevenseg reader path.
//  The operator keys 12-bit words (3 hex nibbles) with one button; each finished word is

---
 rtl/mem_loader.sv | 160 ++++++++++++++++
 tb/tb_mem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Button-driven program writer: keys 12-bit words one nibble at a time and writes them to
// instruction memory at word-aligned, wrapping addresses. Optional readback check: LOADER_VERIFY_EN.
module mem_loader #(
  parameter int MEM_SIZE          = 64,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        button,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [3:0]  edit_val,
  output logic [2:0]  edit_sel,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX    = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [31:0]     LAST_ADDR = 32'(MEM_SIZE - 4);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [1:0] {EDIT = 2'd0, WRITE = 2'd1, NEXT = 2'd2, VERIFY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {EDIT = 2'd0, WRITE = 2'd1, NEXT = 2'd2} state_t;
`endif

  state_t            state_q, state_d;
  logic              btn_meta, btn_sync, db_level, db_toggle;
  logic [DB_W-1:0]   db_cnt;
  logic [LP_W-1:0]   press_timer;
  logic              ev_short, ev_long;
  logic [3:0]        nib0, nib1, nib2;
  logic [31:0]       addr_inc;

  assign state_dbg = state_q;
  assign db_toggle = (btn_sync != db_level) && (db_cnt == DB_LAST);
  assign addr_inc  = wr_addr + 32'd4;

  // Synchroniser, debouncer, press timer and one-cycle press events on debounced release.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      db_level    <= 1'b0;
      db_cnt      <= '0;
      press_timer <= '0;
      ev_short    <= 1'b0;
      ev_long     <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      if (btn_sync == db_level) db_cnt <= '0;
      else if (db_toggle) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else db_cnt <= db_cnt + DB_W'(1);
      if (db_toggle && !db_level) press_timer <= '0;
      else if (db_level && press_timer != LP_MAX) press_timer <= press_timer + LP_W'(1);
      ev_short <= db_toggle && db_level && (press_timer != LP_MAX);
      ev_long  <= db_toggle && db_level && (press_timer == LP_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EDIT:  if (ev_long && edit_sel == 3'b100) state_d = WRITE;
`ifdef LOADER_VERIFY_EN
      WRITE: if (wr_req && wr_ack) state_d = VERIFY;
      VERIFY: state_d = NEXT;
`else
      WRITE: if (wr_req && wr_ack) state_d = NEXT;
`endif
      NEXT:  state_d = EDIT;
      default: state_d = EDIT;
    endcase
  end

  always_comb begin
    edit_val = nib0;
    case (edit_sel)
      3'b010:  edit_val = nib1;
      3'b100:  edit_val = nib2;
      default: edit_val = nib0;
    endcase
  end

  // Handshake: a write transfers on a cycle with wr_req & wr_ack both high; wr_req, wr_addr and
  // wr_data stay stable from wr_req rising until that cycle, and wr_ack alone has no effect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= EDIT;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      nib0     <= '0;
      nib1     <= '0;
      nib2     <= '0;
      edit_sel <= 3'b001;
`ifdef LOADER_VERIFY_EN
      rd_addr  <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        EDIT: begin
          if (ev_short) begin
            case (edit_sel)
              3'b010:  nib1 <= nib1 + 4'd1;
              3'b100:  nib2 <= nib2 + 4'd1;
              default: nib0 <= nib0 + 4'd1;
            endcase
          end else if (ev_long) begin
            if (edit_sel == 3'b100) begin
              wr_data <= {20'd0, nib2, nib1, nib0};
              wr_req  <= 1'b1;
            end else edit_sel <= {edit_sel[1:0], 1'b0};
          end
        end
        WRITE: begin
          if (wr_req && wr_ack) begin
            wr_req <= 1'b0;
`ifdef LOADER_VERIFY_EN
            // Readback address is presented during the acknowledge transition.
            rd_addr <= wr_addr;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        VERIFY: if (rd_data != wr_data) err <= 1'b1;
`endif
        NEXT: begin
          wr_addr  <= (addr_inc > LAST_ADDR) ? 32'd0 : addr_inc;
          nib0     <= '0;
          nib1     <= '0;
          nib2     <= '0;
          edit_sel <= 3'b001;
        end
        default: ;
      endcase
    end
  end

`ifndef LOADER_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign rd_addr   = 32'd0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: keys words through the button, scoreboards each write request and
// checks reset, nibble editing, debounce, address wrap, dropped presses and error flag.
module tb_mem_loader;

  localparam int W        = 64;
  localparam int MEM_SIZE = 16;
`ifdef LOADER_VERIFY_EN
  localparam int       ACK_TO_EDIT = 3;
  localparam logic     EXP_ERR     = 1'b1;
`else
  localparam int       ACK_TO_EDIT = 2;
  localparam logic     EXP_ERR     = 1'b0;
`endif

  logic        sys_clk, sys_rst, button, wr_req, wr_ack, err;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  edit_val;
  logic [2:0]  edit_sel;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [31:0]  addr_model;
  int           checks = 0;
  int           errors = 0;

  mem_loader #(.MEM_SIZE(MEM_SIZE), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .button(button), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .edit_val(edit_val), .edit_sel(edit_sel), .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Memory that never retains data: any readback of a nonzero word mismatches.
  assign rd_data = 32'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks (inputs change on the falling edge, outputs sampled there too)
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1; button = 1'b0; wr_ack = 1'b0;
    cyc(3);
    sys_rst = 1'b0;
    cyc(1);
    addr_model = 32'd0;
    exp_q.delete();
  endtask

  task automatic press(input int len);
    button = 1'b1;
    cyc(len);
    button = 1'b0;
    cyc(12);
  endtask

  task automatic short_press(); press(8);  endtask
  task automatic long_press();  press(40); endtask

  task automatic bounce();
    button = 1'b1;
    cyc(2);
    button = 1'b0;
    cyc(10);
  endtask

  task automatic set_nibble(input int v);
    repeat (v) short_press();
  endtask

  task automatic push_word(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
    exp_q.push_back({addr_model, 20'd0, n2, n1, n0});
    addr_model = (addr_model + 32'd4 > 32'(MEM_SIZE - 4)) ? 32'd0 : addr_model + 32'd4;
  endtask

  task automatic enter_word(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
    set_nibble(int'(n0)); long_press();
    set_nibble(int'(n1)); long_press();
    set_nibble(int'(n2));
    push_word(n0, n1, n2);
    long_press();
  endtask

  task automatic wait_req(output bit ok);
    int waited = 0;
    while (wr_req !== 1'b1 && waited < 300) begin
      cyc(1);
      waited++;
    end
    ok = (wr_req === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wr_req_timeout: wr_req=%b after %0d cycles, required 1", wr_req, waited);
    end
  endtask

  // Scoreboard: pop the expected {addr,data}, hold, acknowledge, check return to EDIT.
  task automatic expect_write(input int delay, input bit press_during);
    bit          ok;
    logic [W-1:0] exp;
    logic [31:0] hold_addr, hold_data;
    wait_req(ok);
    exp = exp_q.pop_front();
    if (!ok) return;
    checks++;
    if ({wr_addr, wr_data} !== exp) begin
      errors++;
      $display("FAIL write_word: addr=%h data=%h, required addr=%h data=%h",
               wr_addr, wr_data, exp[63:32], exp[31:0]);
    end
    hold_addr = wr_addr;
    hold_data = wr_data;
    if (press_during) begin
      short_press();
      long_press();
    end
    cyc(delay);
    checks++;
    if (wr_req !== 1'b1 || wr_addr !== hold_addr || wr_data !== hold_data) begin
      errors++;
      $display("FAIL write_hold: req=%b addr=%h data=%h, required req=1 addr=%h data=%h",
               wr_req, wr_addr, wr_data, hold_addr, hold_data);
    end
    wr_ack = 1'b1;
    cyc(1);
    wr_ack = 1'b0;
    checks++;
    if (wr_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: wr_req=%b, required 0", wr_req);
    end
    cyc(ACK_TO_EDIT - 2);
    checks++;
    if (state_dbg === 2'd0) begin
      errors++;
      $display("FAIL ack_latency_early: state=%0d, required not EDIT", state_dbg);
    end
    cyc(1);
    checks++;
    if (state_dbg !== 2'd0 || wr_addr !== addr_model || edit_sel !== 3'b001 || edit_val !== 4'd0) begin
      errors++;
      $display("FAIL after_write: state=%0d addr=%h sel=%b val=%h, required 0 %h 001 0",
               state_dbg, wr_addr, edit_sel, edit_val, addr_model);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    cyc(100);
    checks++;
    if (wr_req !== 1'b0 || edit_sel !== 3'b001 || edit_val !== 4'd0 || err !== 1'b0 ||
        wr_addr !== 32'd0 || wr_data !== 32'd0 || rd_addr !== 32'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset: req=%b sel=%b val=%h err=%b addr=%h data=%h rd=%h st=%0d, required all idle",
               wr_req, edit_sel, edit_val, err, wr_addr, wr_data, rd_addr, state_dbg);
    end
  endtask

  task automatic test_short_and_bounce();
    set_nibble(3);
    checks++;
    if (edit_val !== 4'd3) begin
      errors++;
      $display("FAIL short_press: edit_val=%h, required 3", edit_val);
    end
    bounce();
    bounce();
    checks++;
    if (edit_val !== 4'd3 || edit_sel !== 3'b001) begin
      errors++;
      $display("FAIL bounce: edit_val=%h sel=%b, required 3 001", edit_val, edit_sel);
    end
  endtask

  task automatic test_nibble_wrap();
    apply_reset();
    set_nibble(17);
    checks++;
    if (edit_val !== 4'd1) begin
      errors++;
      $display("FAIL nibble_wrap: edit_val=%h, required 1", edit_val);
    end
    apply_reset();
  endtask

  task automatic test_word_entry();
    set_nibble(5);
    checks++;
    if (edit_val !== 4'h5) begin
      errors++;
      $display("FAIL nib0_entry: edit_val=%h, required 5", edit_val);
    end
    long_press();
    checks++;
    if (edit_sel !== 3'b010 || edit_val !== 4'h0) begin
      errors++;
      $display("FAIL select_nib1: sel=%b val=%h, required 010 0", edit_sel, edit_val);
    end
    set_nibble(10);
    checks++;
    if (edit_val !== 4'hA) begin
      errors++;
      $display("FAIL nib1_entry: edit_val=%h, required a", edit_val);
    end
    long_press();
    checks++;
    if (edit_sel !== 3'b100 || wr_req !== 1'b0) begin
      errors++;
      $display("FAIL select_nib2: sel=%b req=%b, required 100 0", edit_sel, wr_req);
    end
    set_nibble(3);
    push_word(4'h5, 4'hA, 4'h3);
    long_press();
    expect_write(3, 1'b0);
    checks++;
    if (err !== EXP_ERR) begin
      errors++;
      $display("FAIL err_first_write: err=%b, required %b", err, EXP_ERR);
    end
  endtask

  task automatic test_address_wrap();
    for (int i = 0; i < 4; i++) begin
      enter_word(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      expect_write(int'($urandom_range(0, 5)), i == 1);
    end
  endtask

  task automatic test_ack_ignored();
    wr_ack = 1'b1;
    cyc(3);
    wr_ack = 1'b0;
    cyc(1);
    checks++;
    if (wr_req !== 1'b0 || state_dbg !== 2'd0 || wr_addr !== addr_model) begin
      errors++;
      $display("FAIL stray_ack: req=%b st=%0d addr=%h, required 0 0 %h",
               wr_req, state_dbg, wr_addr, addr_model);
    end
  endtask

  task automatic test_err_sticky();
    cyc(50);
    checks++;
    if (err !== EXP_ERR) begin
      errors++;
      $display("FAIL err_sticky: err=%b, required %b", err, EXP_ERR);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    enter_word(4'h1, 4'h2, 4'h3);
    wait_req(ok);
    void'(exp_q.pop_front());
    @(negedge sys_clk);
    sys_rst = 1'b1;
    cyc(1);
    checks++;
    if (wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write_req: wr_req=%b, required 0", wr_req);
    end
    sys_rst = 1'b0;
    cyc(1);
    checks++;
    if (wr_addr !== 32'd0 || state_dbg !== 2'd0 || err !== 1'b0 || edit_sel !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_write_state: addr=%h st=%0d err=%b sel=%b, required 0 0 0 001",
               wr_addr, state_dbg, err, edit_sel);
    end
    addr_model = 32'd0;
  endtask

  // Sequence and final report
  initial begin
    sys_rst = 1'b1; button = 1'b0; wr_ack = 1'b0; addr_model = 32'd0;
    test_reset();
    test_short_and_bounce();
    test_nibble_wrap();
    test_word_entry();
    test_address_wrap();
    test_ack_ignored();
    test_err_sticky();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
